// File: rtl/ld_ind_seq_if.sv
// Memory bus between the indirect load/store sequencer and the memory.
//   adr  : bus address              (master -> slave)
//   dout : bus write data           (master -> slave)
//   rd   : read strobe              (master -> slave)
//   wr   : write strobe             (master -> slave)
//   din  : bus read data            (slave  -> master)
interface ld_ind_seq_if #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 8
);
   logic [ADDR_W-1:0] adr;
   logic [DATA_W-1:0] dout;
   logic [DATA_W-1:0] din;
   logic              rd;
   logic              wr;

   modport master (output adr, output dout, output rd, output wr, input din);
   modport slave  (input adr, input dout, input rd, input wr, output din);
endinterface

// File: rtl/ld_ind_seq.sv
// Sequencer for LD A,(ptr) / LD (ptr),A with optional HL post-inc/dec.
// One MEM M-cycle on the latched pointer, then one FETCH M-cycle on PC.
// Ports:
//   clk, nreset           : clock, async active-low reset (release synchronised)
//   start, is_store       : request, direction (0 = load, 1 = store)
//   ptr_sel, ptr_mode     : pointer select (BC/DE/HL), update mode (none/inc/dec)
//   reg_bc/de/hl/a/pc     : register file snapshot
//   bus                   : memory bus (adr, dout, rd, wr, din)
//   busy, done, err       : status; done/err are single-cycle pulses
//   a_we, a_wdata         : accumulator write-back (a_wdata follows din while a_we)
//   ptr_we/wsel/wdata     : pointer write-back
module ld_ind_seq #(
   parameter int unsigned TPM    = 4,
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk,
   input  logic              nreset,
   input  logic              start,
   input  logic              is_store,
   input  logic [1:0]        ptr_sel,
   input  logic [1:0]        ptr_mode,
   input  logic [ADDR_W-1:0] reg_bc,
   input  logic [ADDR_W-1:0] reg_de,
   input  logic [ADDR_W-1:0] reg_hl,
   input  logic [DATA_W-1:0] reg_a,
   input  logic [ADDR_W-1:0] reg_pc,
   ld_ind_seq_if.master      bus,
   output logic              busy,
   output logic              a_we,
   output logic [DATA_W-1:0] a_wdata,
   output logic              ptr_we,
   output logic [1:0]        ptr_wsel,
   output logic [ADDR_W-1:0] ptr_wdata,
   output logic              done,
   output logic              err
);

   localparam int unsigned T_W = (TPM > 1) ? $clog2(TPM) : 1;

   typedef enum logic [1:0] {IDLE, MEM, FETCH} state_e;

   // Reset synchroniser: assertion is immediate, release takes two edges
   logic [1:0] rst_sync_q;
   logic       rst_n;

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) rst_sync_q <= 2'b00;
      else         rst_sync_q <= {rst_sync_q[0], 1'b1};
   end

   assign rst_n = rst_sync_q[1];

   state_e            state_q, state_d;
   logic [T_W-1:0]    t_q, t_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic              store_q, store_d;
   logic              upd_q, upd_d;
   logic              dec_q, dec_d;
   logic [DATA_W-1:0] a_q, a_d;

   logic [ADDR_W-1:0] adr_q, adr_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic              rd_q, rd_d;
   logic              wr_q, wr_d;
   logic              busy_q, busy_d;
   logic              a_we_q, a_we_d;
   logic              ptr_we_q, ptr_we_d;
   logic [1:0]        ptr_wsel_q, ptr_wsel_d;
   logic [ADDR_W-1:0] ptr_wdata_q, ptr_wdata_d;
   logic              done_q, done_d;
   logic              err_q, err_d;

   logic              t_last;
   logic              t_last_d;
   logic [ADDR_W-1:0] sel_ptr;

   assign t_last = (t_q == T_W'(TPM - 1));

   // Pointer mux for the request being sampled
   always_comb begin
      sel_ptr = reg_hl;
      case (ptr_sel)
         2'd0:    sel_ptr = reg_bc;
         2'd1:    sel_ptr = reg_de;
         default: sel_ptr = reg_hl;
      endcase
   end

   // Next state, plus outputs computed from the next state so they register in step
   always_comb begin
      state_d     = state_q;
      t_d         = t_q;
      ptr_d       = ptr_q;
      store_d     = store_q;
      upd_d       = upd_q;
      dec_d       = dec_q;
      a_d         = a_q;
      err_d       = 1'b0;
      adr_d       = '0;
      dout_d      = '0;
      rd_d        = 1'b0;
      wr_d        = 1'b0;
      a_we_d      = 1'b0;
      ptr_we_d    = 1'b0;
      ptr_wsel_d  = 2'd0;
      ptr_wdata_d = '0;
      done_d      = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (ptr_sel == 2'd3 || ptr_mode == 2'd3) begin
                  err_d = 1'b1;
               end else begin
                  state_d = MEM;
                  t_d     = '0;
                  ptr_d   = sel_ptr;
                  store_d = is_store;
                  // Post-inc/dec only exists for HL; other pointers quietly ignore it
                  upd_d   = (ptr_sel == 2'd2) && (ptr_mode != 2'd0);
                  dec_d   = (ptr_mode == 2'd2);
                  a_d     = reg_a;
               end
            end
         end
         MEM: begin
            if (t_last) begin
               state_d = FETCH;
               t_d     = '0;
            end else begin
               t_d = t_q + T_W'(1);
            end
         end
         FETCH: begin
            if (t_last) begin
               state_d = IDLE;
               t_d     = '0;
            end else begin
               t_d = t_q + T_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            t_d     = '0;
         end
      endcase

      busy_d   = (state_d != IDLE);
      t_last_d = (t_d == T_W'(TPM - 1));

      case (state_d)
         MEM: begin
            adr_d = ptr_d;
            if (store_d) begin
               dout_d = a_d;
               // Write strobe sits inside the address window on both sides
               wr_d   = (t_d != '0) && !t_last_d;
            end else begin
               rd_d   = 1'b1;
               a_we_d = t_last_d;
            end
            if (upd_d && t_last_d) begin
               ptr_we_d    = 1'b1;
               ptr_wsel_d  = 2'd2;
               ptr_wdata_d = dec_d ? (ptr_d - ADDR_W'(1)) : (ptr_d + ADDR_W'(1));
            end
         end
         FETCH: begin
            adr_d  = reg_pc;
            rd_d   = 1'b1;
            done_d = t_last_d;
         end
         default: ;
      endcase
   end

   // State and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         t_q         <= '0;
         ptr_q       <= '0;
         store_q     <= 1'b0;
         upd_q       <= 1'b0;
         dec_q       <= 1'b0;
         a_q         <= '0;
         adr_q       <= '0;
         dout_q      <= '0;
         rd_q        <= 1'b0;
         wr_q        <= 1'b0;
         busy_q      <= 1'b0;
         a_we_q      <= 1'b0;
         ptr_we_q    <= 1'b0;
         ptr_wsel_q  <= 2'd0;
         ptr_wdata_q <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         t_q         <= t_d;
         ptr_q       <= ptr_d;
         store_q     <= store_d;
         upd_q       <= upd_d;
         dec_q       <= dec_d;
         a_q         <= a_d;
         adr_q       <= adr_d;
         dout_q      <= dout_d;
         rd_q        <= rd_d;
         wr_q        <= wr_d;
         busy_q      <= busy_d;
         a_we_q      <= a_we_d;
         ptr_we_q    <= ptr_we_d;
         ptr_wsel_q  <= ptr_wsel_d;
         ptr_wdata_q <= ptr_wdata_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign bus.adr   = adr_q;
   assign bus.dout  = dout_q;
   assign bus.rd    = rd_q;
   assign bus.wr    = wr_q;
   assign busy      = busy_q;
   assign a_we      = a_we_q;
   // Read data arrives in the same T-cycle it is written back, so it passes straight through
   assign a_wdata   = a_we_q ? bus.din : '0;
   assign ptr_we    = ptr_we_q;
   assign ptr_wsel  = ptr_wsel_q;
   assign ptr_wdata = ptr_wdata_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: tb/tb_ld_ind_seq.sv
// Directed bench for ld_ind_seq at TPM=4, ADDR_W=16, DATA_W=8.
module tb_ld_ind_seq;

   localparam logic [15:0] PC = 16'h0100;

   logic        clk = 1'b0;
   logic        nreset;
   logic        start;
   logic        is_store;
   logic [1:0]  ptr_sel;
   logic [1:0]  ptr_mode;
   logic [15:0] reg_bc, reg_de, reg_hl, reg_pc;
   logic [7:0]  reg_a;
   logic        busy, a_we, ptr_we, done, err;
   logic [7:0]  a_wdata;
   logic [1:0]  ptr_wsel;
   logic [15:0] ptr_wdata;

   int total = 0;
   int bad   = 0;

   ld_ind_seq_if #(.ADDR_W(16), .DATA_W(8)) bus ();

   ld_ind_seq #(.TPM(4), .ADDR_W(16), .DATA_W(8)) dut (
      .clk       (clk),
      .nreset    (nreset),
      .start     (start),
      .is_store  (is_store),
      .ptr_sel   (ptr_sel),
      .ptr_mode  (ptr_mode),
      .reg_bc    (reg_bc),
      .reg_de    (reg_de),
      .reg_hl    (reg_hl),
      .reg_a     (reg_a),
      .reg_pc    (reg_pc),
      .bus       (bus.master),
      .busy      (busy),
      .a_we      (a_we),
      .a_wdata   (a_wdata),
      .ptr_we    (ptr_we),
      .ptr_wsel  (ptr_wsel),
      .ptr_wdata (ptr_wdata),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Idle-state outputs, checked together
   task automatic chk_idle(input string tag);
      chk({tag, " busy"}, 32'(busy), 32'd0);
      chk({tag, " rd"}, 32'(bus.rd), 32'd0);
      chk({tag, " wr"}, 32'(bus.wr), 32'd0);
      chk({tag, " adr"}, 32'(bus.adr), 32'd0);
      chk({tag, " dout"}, 32'(bus.dout), 32'd0);
      chk({tag, " done"}, 32'(done), 32'd0);
      chk({tag, " a_we"}, 32'(a_we), 32'd0);
      chk({tag, " ptr_we"}, 32'(ptr_we), 32'd0);
   endtask

   // Runs one instruction from an IDLE negedge and checks all eight cycles plus the IDLE after
   task automatic run_instr(input logic st, input logic [1:0] sel, input logic [1:0] mode,
                            input logic [15:0] exp_adr, input logic [7:0] a_val,
                            input logic upd, input logic [15:0] exp_pw,
                            input logic [7:0] din_val, input logic disturb);
      logic mem, last, e_rd, e_wr, e_awe, e_pwe;
      logic [7:0] e_dout, e_awd;
      logic [15:0] e_adr, e_pwd;
      string t;
      is_store = st;
      ptr_sel  = sel;
      ptr_mode = mode;
      start    = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (c == 0) start = 1'b0;
         bus.din = (c == 3) ? din_val : 8'hEE;
         if (disturb && c == 1) begin
            reg_bc = reg_bc ^ 16'hFFFF;
            reg_de = reg_de ^ 16'hFFFF;
            reg_hl = reg_hl ^ 16'hFFFF;
            reg_a  = ~reg_a;
         end
         if (disturb && c == 5) start = 1'b1;
         if (disturb && c == 6) start = 1'b0;
         #1;
         mem    = (c < 4);
         last   = (c == 3);
         e_adr  = mem ? exp_adr : PC;
         e_rd   = mem ? !st : 1'b1;
         e_wr   = st && (c == 1 || c == 2);
         e_dout = (st && mem) ? a_val : 8'h00;
         e_awe  = !st && last;
         e_awd  = e_awe ? din_val : 8'h00;
         e_pwe  = upd && last;
         e_pwd  = e_pwe ? exp_pw : 16'h0000;
         t = $sformatf("c%0d", c);
         chk({t, " adr"}, 32'(bus.adr), 32'(e_adr));
         chk({t, " rd"}, 32'(bus.rd), 32'(e_rd));
         chk({t, " wr"}, 32'(bus.wr), 32'(e_wr));
         chk({t, " dout"}, 32'(bus.dout), 32'(e_dout));
         chk({t, " busy"}, 32'(busy), 32'd1);
         chk({t, " a_we"}, 32'(a_we), 32'(e_awe));
         chk({t, " a_wdata"}, 32'(a_wdata), 32'(e_awd));
         chk({t, " ptr_we"}, 32'(ptr_we), 32'(e_pwe));
         chk({t, " ptr_wsel"}, 32'(ptr_wsel), e_pwe ? 32'd2 : 32'd0);
         chk({t, " ptr_wdata"}, 32'(ptr_wdata), 32'(e_pwd));
         chk({t, " done"}, 32'(done), (c == 7) ? 32'd1 : 32'd0);
         chk({t, " err"}, 32'(err), 32'd0);
      end
      @(negedge clk);
      #1;
      chk_idle("after");
   endtask

   initial begin
      nreset   = 1'b1;
      start    = 1'b0;
      is_store = 1'b0;
      ptr_sel  = 2'd0;
      ptr_mode = 2'd0;
      reg_bc   = 16'hC000;
      reg_de   = 16'hD000;
      reg_hl   = 16'h8000;
      reg_a    = 8'h11;
      reg_pc   = PC;
      bus.din  = 8'hEE;

      // Reset state
      #2 nreset = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk_idle("reset");
      chk("reset err", 32'(err), 32'd0);
      @(negedge clk);
      nreset = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk_idle("post-reset");

      // Load from BC
      run_instr(1'b0, 2'd0, 2'd0, 16'hC000, 8'h11, 1'b0, 16'h0000, 8'h5A, 1'b0);

      // Store via HL with post-increment wrapping to zero (back-to-back)
      reg_hl = 16'hFFFF;
      reg_a  = 8'h33;
      run_instr(1'b1, 2'd2, 2'd1, 16'hFFFF, 8'h33, 1'b1, 16'h0000, 8'h00, 1'b0);

      // Load via HL with post-decrement wrapping to max
      reg_hl = 16'h0000;
      run_instr(1'b0, 2'd2, 2'd2, 16'h0000, 8'h33, 1'b1, 16'hFFFF, 8'hA5, 1'b0);

      // DE load, mode ignored for DE, registers disturbed mid-MEM, start pulsed in FETCH
      reg_de = 16'hBEEF;
      reg_a  = 8'h44;
      run_instr(1'b0, 2'd1, 2'd1, 16'hBEEF, 8'h44, 1'b0, 16'h0000, 8'h3C, 1'b1);

      // Rejected requests: reserved pointer, then reserved mode
      for (int k = 0; k < 2; k++) begin
         ptr_sel  = (k == 0) ? 2'd3 : 2'd0;
         ptr_mode = (k == 0) ? 2'd0 : 2'd3;
         start    = 1'b1;
         @(negedge clk);
         start = 1'b0;
         #1;
         chk($sformatf("rej%0d err", k), 32'(err), 32'd1);
         chk($sformatf("rej%0d busy", k), 32'(busy), 32'd0);
         chk($sformatf("rej%0d rd", k), 32'(bus.rd), 32'd0);
         chk($sformatf("rej%0d wr", k), 32'(bus.wr), 32'd0);
         @(negedge clk);
         #1;
         chk($sformatf("rej%0d err clr", k), 32'(err), 32'd0);
         chk_idle($sformatf("rej%0d", k));
      end

      // Reset asserted during MEM cycle 2 of a store
      reg_hl   = 16'h1000;
      reg_a    = 8'h77;
      is_store = 1'b1;
      ptr_sel  = 2'd2;
      ptr_mode = 2'd1;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("mid wr before reset", 32'(bus.wr), 32'd1);
      #1 nreset = 1'b0;
      #1;
      chk("mid wr", 32'(bus.wr), 32'd0);
      chk("mid busy", 32'(busy), 32'd0);
      chk("mid adr", 32'(bus.adr), 32'd0);
      chk("mid dout", 32'(bus.dout), 32'd0);
      @(negedge clk);
      nreset = 1'b1;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         #1;
         chk($sformatf("post-int%0d ptr_we", k), 32'(ptr_we), 32'd0);
         chk($sformatf("post-int%0d done", k), 32'(done), 32'd0);
         chk($sformatf("post-int%0d a_we", k), 32'(a_we), 32'd0);
         chk($sformatf("post-int%0d busy", k), 32'(busy), 32'd0);
      end

      // Fresh store after the interrupted one
      run_instr(1'b1, 2'd2, 2'd1, 16'h1000, 8'h77, 1'b1, 16'h1001, 8'h00, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ld_ind_seq.md
LD_IND_SEQ -- requirements
Module: ld_ind_seq

Interface
REQ-001 SHALL have parameter TPM, default 4: T-cycles per M-cycle; legal range 3..8.
REQ-002 SHALL have parameter ADDR_W, default 16: address and pointer width.
REQ-003 SHALL have parameter DATA_W, default 8: data width.
REQ-004 SHALL have ports:
- clk  in  1  sole clock; all state on rising edge
- nreset  in  1  asynchronous active-low reset
- start  in  1  request a new instruction; sampled only in IDLE
- is_store  in  1  0 = LD A,(ptr); 1 = LD (ptr),A
- ptr_sel  in  2  0 = BC, 1 = DE, 2 = HL, 3 = reserved
- ptr_mode  in  2  0 = none, 1 = post-increment, 2 = post-decrement, 3 = reserved
- reg_bc, reg_de, reg_hl  in  ADDR_W  current pointer register values
- reg_a  in  DATA_W  current accumulator
- reg_pc  in  ADDR_W  address of the next opcode
- din  in  DATA_W  bus read data
- adr  out  ADDR_W  bus address
- dout  out  DATA_W  bus write data
- rd, wr  out  1  bus read and write strobes
- busy  out  1  high in every state except IDLE
- a_we  out  1  accumulator write enable
- a_wdata  out  DATA_W  accumulator write data
- ptr_we  out  1  pointer write enable
- ptr_wsel  out  2  pointer being written back; same encoding as ptr_sel
- ptr_wdata  out  ADDR_W  updated pointer value
- done  out  1  one-cycle pulse on the last T-cycle of FETCH
- err  out  1  one-cycle pulse when a request is rejected

Function
REQ-005 SHALL implement states IDLE, MEM and FETCH, plus a T-counter t that runs 0..TPM-1 and wraps.
REQ-006 IDLE with start=1 and legal inputs SHALL latch the selected pointer, is_store, ptr_mode and reg_a, then move to MEM with t=0 on the next edge.
REQ-007 In IDLE, start with ptr_sel=3, or with ptr_mode=3, SHALL pulse err for one cycle and remain in IDLE.
REQ-008 A ptr_mode other than 0 with ptr_sel != 2 SHALL be treated as ptr_mode 0, with no err.
REQ-009 start SHALL be ignored while busy=1.
REQ-010 In MEM, adr SHALL equal the latched pointer for all TPM cycles; later changes to reg_bc, reg_de, reg_hl or reg_a SHALL have no effect.
REQ-011 MEM load: rd=1 for all TPM cycles; din is captured on the edge ending t=TPM-1.
REQ-012 MEM store: dout = latched reg_a for all TPM cycles; wr=1 only for t=1..TPM-2; rd=0.
REQ-013 Load: a_we=1 and a_wdata=din during t=TPM-1 of MEM, as a single cycle.
REQ-014 Store: a_we SHALL never assert.
REQ-015 Pointer update (ptr_sel=2, mode 1 or 2): ptr_we=1 for one cycle at t=TPM-1 of MEM, with ptr_wsel=2 and ptr_wdata = pointer +1 or -1 modulo 2^ADDR_W (max+1 -> 0, 0-1 -> max).
REQ-016 Without a pointer update, ptr_we SHALL stay 0.
REQ-017 MEM t=TPM-1 SHALL go to FETCH with t=0.
REQ-018 In FETCH, adr=reg_pc and rd=1 for TPM cycles; wr=0.
REQ-019 FETCH t=TPM-1 SHALL pulse done and return to IDLE.
REQ-020 Total instruction latency from start accepted to done SHALL be exactly 2*TPM cycles.
REQ-021 Next start SHALL be accepted no earlier than the cycle after done; back-to-back operation gives one IDLE cycle between instructions.
REQ-022 rd and wr SHALL never be high together.
REQ-023 Outside MEM and FETCH: rd=wr=0, adr=0, dout=0.

Reset
REQ-024 nreset=0 SHALL immediately force state=IDLE, t=0, and all outputs to 0, including while mid-instruction.
REQ-025 An interrupted instruction SHALL produce no a_we, ptr_we or done after reset releases.
REQ-026 Release of nreset SHALL be synchronised internally so the first active edge sees a stable IDLE.

Verification (TPM=4, ADDR_W=16, DATA_W=8)
REQ-027 Load (ptr_sel=0, BC=0xC000, din=0x5A at cycle 3) -> adr=0xC000 for cycles 0-3; a_we at cycle 3 with 0x5A; adr=PC for cycles 4-7; done at cycle 7.
REQ-028 Store (ptr_sel=2, mode=1, HL=0xFFFF, A=0x33) -> wr only in cycles 1-2 with dout=0x33; ptr_we at cycle 3 with ptr_wdata=0x0000; no a_we.
REQ-029 Load (ptr_sel=2, mode=2, HL=0x0000) -> ptr_wdata=0xFFFF; the load still reads address 0x0000.
REQ-030 start with ptr_sel=3 -> err pulse, busy stays 0, no rd or wr.
REQ-031 nreset low during MEM cycle 2 of a store -> wr drops immediately; no ptr_we or done afterwards; a fresh start runs a normal instruction.
REQ-032 reg_de changes during MEM of a DE load -> adr is unchanged; start pulsed during FETCH is ignored.
